// File: rtl/alu_issue.sv
// Single-entry ALU issue stage: decodes one request, drives registered operands
// and select to an external ALU, captures its result and holds it until consumed.
module alu_issue #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   alu_op,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    input  logic [n-1:0] rs1,
    input  logic [n-1:0] rs2,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [n-1:0] alu_out,
    input  logic         alu_zero,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [n-1:0] res_data,
    output logic         res_taken,
    output logic         res_illegal,
    output logic [15:0]  op_count
);

    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic       illegal;
        logic       beq;
        logic       bne;
        logic [3:0] sel;
    } dec_t;

    function automatic dec_t decode(input logic [1:0] op, input logic [2:0] f3, input logic f7);
        dec_t d;
        d = '{illegal: 1'b1, beq: 1'b0, bne: 1'b0, sel: SEL_AND};
        case (op)
            2'b00: begin
                d.illegal = 1'b0;
                d.sel     = SEL_ADD;
            end
            2'b01: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    d.illegal = 1'b0;
                    d.sel     = SEL_SUB;
                    d.beq     = (f3 == 3'b000);
                    d.bne     = (f3 == 3'b001);
                end
            end
            2'b10: begin
                case (f3)
                    3'b000: begin d.illegal = 1'b0; d.sel = f7 ? SEL_SUB : SEL_ADD; end
                    3'b111: begin d.illegal = 1'b0; d.sel = SEL_AND; end
                    3'b110: begin d.illegal = 1'b0; d.sel = SEL_OR;  end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return d;
    endfunction

    state_t state;
    dec_t   dec;
    logic   is_beq;
    logic   is_bne;

    assign dec = decode(alu_op, funct3, funct7_5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_taken   <= 1'b0;
            res_illegal <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= SEL_AND;
            is_beq      <= 1'b0;
            is_bne      <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        alu_a    <= rs1;
                        alu_b    <= rs2;
                        if (dec.illegal) begin
                            // Illegal requests bypass the ALU; the previous select is left in place.
                            res_data    <= '0;
                            res_taken   <= 1'b0;
                            res_illegal <= 1'b1;
                            res_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            alu_sel <= dec.sel;
                            is_beq  <= dec.beq;
                            is_bne  <= dec.bne;
                            state   <= EXEC;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    res_data    <= alu_out;
                    res_taken   <= is_beq ? alu_zero : (is_bne & ~alu_zero);
                    res_illegal <= 1'b0;
                    res_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a combinational ALU model attached.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1, rs2;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_taken;
    logic        res_illegal;
    logic [15:0] op_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue #(.n(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .rs1(rs1), .rs2(rs2), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_taken(res_taken),
        .res_illegal(res_illegal), .op_count(op_count)
    );

    // ALU model
    always_comb begin
        case (alu_sel)
            4'b0010: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            default: alu_out = 32'h0;
        endcase
    end
    assign alu_zero = (alu_out == 32'h0);

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
        logic [3:0]  sel;
        logic [31:0] data;
        logic        taken;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; funct3 = f3; funct7_5 = f7; rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]  prev_sel;
        logic [3:0]  exp_sel;
        logic [15:0] cnt;

        vecs[0]  = '{2'b10, 3'b000, 1'b0, 32'd5,        32'd7,        1'b0, 4'b0010, 32'd12,       1'b0};
        vecs[1]  = '{2'b01, 3'b000, 1'b0, 32'h1234,     32'h1234,     1'b0, 4'b0110, 32'd0,        1'b1};
        vecs[2]  = '{2'b01, 3'b001, 1'b0, 32'h1234,     32'h1234,     1'b0, 4'b0110, 32'd0,        1'b0};
        vecs[3]  = '{2'b01, 3'b001, 1'b0, 32'd9,        32'd4,        1'b0, 4'b0110, 32'd5,        1'b1};
        vecs[4]  = '{2'b01, 3'b000, 1'b0, 32'd9,        32'd4,        1'b0, 4'b0110, 32'd5,        1'b0};
        vecs[5]  = '{2'b10, 3'b000, 1'b1, 32'd10,       32'd3,        1'b0, 4'b0110, 32'd7,        1'b0};
        vecs[6]  = '{2'b10, 3'b111, 1'b0, 32'hF0F0,     32'hFF00,     1'b0, 4'b0000, 32'hF000,     1'b0};
        vecs[7]  = '{2'b10, 3'b110, 1'b0, 32'hF0F0,     32'h0F00,     1'b0, 4'b0001, 32'hFFF0,     1'b0};
        vecs[8]  = '{2'b11, 3'b000, 1'b0, 32'd77,       32'd88,       1'b1, 4'b0000, 32'd0,        1'b0};
        vecs[9]  = '{2'b00, 3'b101, 1'b1, 32'd100,      32'hFFFFFFFF, 1'b0, 4'b0010, 32'd99,       1'b0};
        vecs[10] = '{2'b01, 3'b100, 1'b0, 32'd3,        32'd3,        1'b1, 4'b0000, 32'd0,        1'b0};
        vecs[11] = '{2'b10, 3'b001, 1'b0, 32'd1,        32'd2,        1'b1, 4'b0000, 32'd0,        1'b0};
        vecs[12] = '{2'b10, 3'b000, 1'b1, 32'd0,        32'd1,        1'b0, 4'b0110, 32'hFFFFFFFF, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; rs1 = '0; rs2 = '0;

        // Reset state
        #22;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_op_count", {16'b0, op_count}, 32'd0);
        chk("rst_alu_sel", {28'b0, alu_sel}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed vectors, consumer always ready
        res_ready = 1'b1;
        prev_sel  = 4'b0000;
        cnt       = 16'd0;
        for (int k = 0; k < 13; k++) begin
            exp_sel = vecs[k].ill ? prev_sel : vecs[k].sel;
            chk($sformatf("v%0d_in_ready_before", k), {31'b0, in_ready}, 32'd1);
            issue(vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].a, vecs[k].b);
            chk($sformatf("v%0d_alu_a", k), alu_a, vecs[k].a);
            chk($sformatf("v%0d_alu_b", k), alu_b, vecs[k].b);
            chk($sformatf("v%0d_alu_sel", k), {28'b0, alu_sel}, {28'b0, exp_sel});
            chk($sformatf("v%0d_in_ready_busy", k), {31'b0, in_ready}, 32'd0);
            chk($sformatf("v%0d_valid_at_T", k), {31'b0, res_valid}, {31'b0, vecs[k].ill});
            if (!vecs[k].ill) begin
                @(posedge clk); #1;
                chk($sformatf("v%0d_valid_at_T1", k), {31'b0, res_valid}, 32'd1);
            end
            chk($sformatf("v%0d_res_data", k), res_data, vecs[k].data);
            chk($sformatf("v%0d_res_taken", k), {31'b0, res_taken}, {31'b0, vecs[k].taken});
            chk($sformatf("v%0d_res_illegal", k), {31'b0, res_illegal}, {31'b0, vecs[k].ill});
            @(posedge clk); #1;
            cnt = cnt + 16'd1;
            chk($sformatf("v%0d_valid_cleared", k), {31'b0, res_valid}, 32'd0);
            chk($sformatf("v%0d_in_ready_back", k), {31'b0, in_ready}, 32'd1);
            chk($sformatf("v%0d_op_count", k), {16'b0, op_count}, {16'b0, cnt});
            prev_sel = exp_sel;
        end

        // Back-pressure with stray requests while the result is held
        res_ready = 1'b0;
        issue(2'b10, 3'b000, 1'b0, 32'd20, 32'd22);
        @(posedge clk); #1;
        chk("bp_valid", {31'b0, res_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0] ? 1'b0 : 1'b1;
            alu_op = 2'b00; rs1 = 32'd1000 + 32'(i); rs2 = 32'd3;
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", i), {31'b0, res_valid}, 32'd1);
            chk($sformatf("bp%0d_data", i), res_data, 32'd42);
            chk($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_alu_a", i), alu_a, 32'd20);
            chk($sformatf("bp%0d_op_count", i), {16'b0, op_count}, {16'b0, cnt});
        end
        @(negedge clk);
        in_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        cnt = cnt + 16'd1;
        chk("bp_release_valid", {31'b0, res_valid}, 32'd0);
        chk("bp_release_count", {16'b0, op_count}, {16'b0, cnt});
        @(posedge clk); #1;
        chk("bp_single_handshake", {16'b0, op_count}, {16'b0, cnt});
        chk("bp_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset while in EXEC
        issue(2'b10, 3'b000, 1'b0, 32'd1, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, res_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_alu_sel", {28'b0, alu_sel}, 32'd0);
        chk("mid_rst_res_data", res_data, 32'd0);
        chk("mid_rst_op_count", {16'b0, op_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rel_valid", {31'b0, res_valid}, 32'd0);
        chk("rel_op_count", {16'b0, op_count}, 32'd0);

        // Counter wrap: preload the count instead of running 65535 handshakes
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        issue(2'b00, 3'b000, 1'b0, 32'd1, 32'd1);
        @(posedge clk); #1;
        chk("wrap_data", res_data, 32'd2);
        @(posedge clk); #1;
        chk("wrap_op_count", {16'b0, op_count}, 32'd0);
        chk("wrap_in_ready", {31'b0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter n, default 32: operand and result width in bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 alu_op  input  2  operation class: 00 = mem-address add, 01 = branch, 10 = R-type, 11 = reserved.
REQ-007 funct3  input  3  instruction funct3 field.
REQ-008 funct7_5  input  1  instruction bit 30.
REQ-009 rs1, rs2  input  n each  source operands.
REQ-010 alu_a, alu_b  output  n each  registered operands driven to the ALU.
REQ-011 alu_sel  output  4  registered ALU select: 0010 = add, 0110 = sub, 0000 = and, 0001 = or.
REQ-012 alu_out  input  n  ALU result, combinational from alu_a, alu_b and alu_sel.
REQ-013 alu_zero  input  1  ALU zero flag.
REQ-014 res_valid  output  1  result valid.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_data  output  n  captured ALU result.
REQ-017 res_taken  output  1  branch-taken flag.
REQ-018 res_illegal  output  1  request decoded as illegal.
REQ-019 op_count  output  16  number of completed result handshakes; wraps from 0xFFFF to 0.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, EXEC and DONE; it holds at most one request at a time (no pipelining).
REQ-021 in_ready SHALL be a registered output that is 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-022 On accept, the block SHALL latch rs1 into alu_a, rs2 into alu_b and the decoded select into alu_sel, then go to EXEC, or to DONE if the request is illegal.
REQ-023 Decode SHALL be:
- alu_op 00 -> 0010 (add).
- alu_op 01 with funct3 000 (BEQ) or 001 (BNE) -> 0110 (sub).
- alu_op 10:
  - funct3 000 with funct7_5 = 0 -> 0010 (add).
  - funct3 000 with funct7_5 = 1 -> 0110 (sub).
  - funct3 111 -> 0000 (and).
  - funct3 110 -> 0001 (or).
- Everything else, including all of alu_op 11, is illegal.
REQ-024 In EXEC (exactly one cycle), the block SHALL capture alu_out into res_data at the closing edge and compute res_taken, then go to DONE.
- res_taken = alu_zero for BEQ.
- res_taken = NOT alu_zero for BNE.
- res_taken = 0 for every non-branch request.
REQ-025 For an illegal request, the block SHALL skip EXEC and enter DONE with res_data = 0, res_taken = 0, res_illegal = 1; for a legal request res_illegal = 0.
REQ-026 In DONE, res_valid SHALL be 1 and res_data, res_taken and res_illegal SHALL hold stable until res_ready = 1.
REQ-027 A DONE-state handshake SHALL:
- clear res_valid;
- increment op_count;
- return the FSM to IDLE;
- set in_ready to 1 on the same edge.
REQ-028 Latency SHALL be as follows, taking the accept edge as T:
- legal request: res_valid is 1 in the cycle after edge T+1;
- illegal request: res_valid is 1 in the cycle after edge T;
- the next accept is possible at the edge after the result handshake.
REQ-029 alu_a, alu_b and alu_sel SHALL keep their values outside EXEC; they change only on accept.
REQ-030 in_valid during EXEC or DONE SHALL be ignored and SHALL NOT corrupt any state.

Reset
REQ-031 When rst_n is 0, the block SHALL asynchronously force:
- state = IDLE;
- in_ready = 0 and res_valid = 0;
- res_data = 0, res_taken = 0, res_illegal = 0;
- alu_a = 0, alu_b = 0, alu_sel = 0000;
- op_count = 0.
REQ-032 in_ready SHALL become 1 at the first rising edge after rst_n returns to 1.
REQ-033 Reset asserted in EXEC or DONE SHALL abandon the in-flight request without producing any result handshake.

Verification
REQ-034 R-type add: alu_op = 10, funct3 = 000, funct7_5 = 0, rs1 = 5, rs2 = 7 (with the ALU model attached), res_ready = 1 -> alu_sel = 0010; res_valid rises two edges after accept; res_data = 12; res_illegal = 0; op_count = 1.
REQ-035 BEQ: alu_op = 01, funct3 = 000, rs1 = rs2 = 0x1234 -> alu_sel = 0110, res_data = 0, res_taken = 1. BNE with the same operands -> res_taken = 0.
REQ-036 Illegal request: alu_op = 11 -> res_valid rises one edge after accept; res_illegal = 1; res_data = 0; alu_sel unchanged from the prior request.
REQ-037 Back-pressure: hold res_ready = 0 for 5 cycles while toggling in_valid with different rs1 values -> outputs stay stable, in_ready stays 0, and there is exactly one handshake when res_ready = 1.
REQ-038 Reset mid-operation: drop rst_n in EXEC -> all outputs are 0 immediately; in_ready = 1 one edge after release; op_count = 0.
REQ-039 Counter wrap: preload op_count to 0xFFFF via 65535 handshakes -> the next handshake yields op_count = 0x0000.
